// File: rtl/per2axi_res_buffer.sv
// ----------------------------------------------------------------------------
// per2axi_res_buffer
//
// Response path from an AXI4 master back to the peripheral interconnect.
// Each tracked read ID keeps a small FIFO of 32-bit lane offsets. The offset
// is captured from the request address so the matching R beat can be narrowed
// to the addressed lane. R and B share one registered output stage. Access to
// it is arbitrated round-robin, and the stage honours peripheral back-pressure.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   per_slave_r_*            registered peripheral response (valid/ready,
//                            opc = resp[1], one-hot id, 32-bit rdata)
//   axi_master_r_*           AXI R channel (data lane selected by offset FIFO)
//   axi_master_b_*           AXI B channel (rdata forced to zero)
//   trans_req_i/we_i/id_i/add_i  upstream request, used to record read lanes
//   trans_ready_o            request can be tracked (offset FIFO not full)
// ----------------------------------------------------------------------------
module per2axi_res_buffer #(
    parameter int PER_ID_WIDTH   = 5,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_USER_WIDTH = 6,
    parameter int AXI_ID_WIDTH   = 3,
    parameter int OFFSET_DEPTH   = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    output logic                      per_slave_r_valid_o,
    input  logic                      per_slave_r_ready_i,
    output logic                      per_slave_r_opc_o,
    output logic [PER_ID_WIDTH-1:0]   per_slave_r_id_o,
    output logic [31:0]               per_slave_r_rdata_o,

    input  logic                      axi_master_r_valid_i,
    input  logic [AXI_DATA_WIDTH-1:0] axi_master_r_data_i,
    input  logic [1:0]                axi_master_r_resp_i,
    input  logic                      axi_master_r_last_i,
    input  logic [AXI_ID_WIDTH-1:0]   axi_master_r_id_i,
    input  logic [AXI_USER_WIDTH-1:0] axi_master_r_user_i,
    output logic                      axi_master_r_ready_o,

    input  logic                      axi_master_b_valid_i,
    input  logic [1:0]                axi_master_b_resp_i,
    input  logic [AXI_ID_WIDTH-1:0]   axi_master_b_id_i,
    input  logic [AXI_USER_WIDTH-1:0] axi_master_b_user_i,
    output logic                      axi_master_b_ready_o,

    input  logic                      trans_req_i,
    input  logic                      trans_we_i,
    input  logic [AXI_ID_WIDTH-1:0]   trans_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0] trans_add_i,
    output logic                      trans_ready_o
);

    localparam int NLANE  = AXI_DATA_WIDTH / 32;
    localparam int LANE_W = $clog2(NLANE);
    localparam int PTR_W  = (OFFSET_DEPTH > 1) ? $clog2(OFFSET_DEPTH) : 1;
    localparam int CNT_W  = $clog2(OFFSET_DEPTH) + 1;

    // Offset FIFO state, one FIFO per tracked ID
    logic [LANE_W-1:0] mem_q    [PER_ID_WIDTH][OFFSET_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q [PER_ID_WIDTH];
    logic [PTR_W-1:0]  wr_ptr_q [PER_ID_WIDTH];
    logic [CNT_W-1:0]  cnt_q    [PER_ID_WIDTH];

    logic [PER_ID_WIDTH-1:0] full, empty, push, pop;
    logic [PER_ID_WIDTH-1:0] r_onehot, b_onehot;
    logic                    t_in_range, r_in_range, b_in_range;
    logic                    t_full, r_empty;
    logic [LANE_W-1:0]       head_lane;
    logic [31:0]             rdata_sel;
    logic                    r_req, b_req, grant_r, grant_b, r_fire, b_fire, out_free;

    // Output stage and arbitration pointer (0 = R preferred, 1 = B preferred)
    logic                    valid_q, valid_d;
    logic                    opc_q, opc_d;
    logic [PER_ID_WIDTH-1:0] id_q, id_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    arb_ptr_q, arb_ptr_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OFFSET_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign t_in_range = 32'(trans_id_i) < PER_ID_WIDTH;
    assign r_in_range = 32'(axi_master_r_id_i) < PER_ID_WIDTH;
    assign b_in_range = 32'(axi_master_b_id_i) < PER_ID_WIDTH;

    // Per-ID status plus selection by request / R / B ID
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        full      = '0;
        empty     = '0;
        r_onehot  = '0;
        b_onehot  = '0;
        t_full    = 1'b0;
        r_empty   = 1'b1;
        head_lane = '0;
        for (int k = 0; k < PER_ID_WIDTH; k++) begin
            full[k]     = (cnt_q[k] == CNT_W'(OFFSET_DEPTH));
            empty[k]    = (cnt_q[k] == '0);
            r_onehot[k] = (32'(axi_master_r_id_i) == k);
            b_onehot[k] = (32'(axi_master_b_id_i) == k);
            if (32'(trans_id_i) == k) t_full = full[k];
            if (r_onehot[k]) begin
                r_empty = empty[k];
                // An R beat on an empty FIFO is a protocol error: fall back to lane 0.
                if (!empty[k]) head_lane = mem_q[k][rd_ptr_q[k]];
            end
        end
    end

    always_comb begin
        rdata_sel = '0;
        for (int l = 0; l < NLANE; l++) begin
            if (32'(head_lane) == l) rdata_sel = axi_master_r_data_i[32*l +: 32];
        end
    end

    // Round-robin arbitration between in-range R and B
    assign out_free = ~valid_q | per_slave_r_ready_i;
    assign r_req    = axi_master_r_valid_i & r_in_range;
    assign b_req    = axi_master_b_valid_i & b_in_range;
    assign grant_r  = r_req & (~b_req | ~arb_ptr_q);
    assign grant_b  = b_req & (~r_req |  arb_ptr_q);
    assign r_fire   = grant_r & out_free;
    assign b_fire   = grant_b & out_free;

    // Out-of-range beats are always accepted and dropped
    assign axi_master_r_ready_o = ~r_in_range | (out_free & (~r_req | grant_r));
    assign axi_master_b_ready_o = ~b_in_range | (out_free & (~b_req | grant_b));

    // Full is sampled before any same-cycle pop, so a full FIFO refuses the push
    assign trans_ready_o = trans_we_i | ~t_in_range | ~t_full;

    always_comb begin
        push = '0;
        pop  = '0;
        for (int k = 0; k < PER_ID_WIDTH; k++) begin
            push[k] = trans_req_i & ~trans_we_i & t_in_range & ~t_full & (32'(trans_id_i) == k);
            pop[k]  = r_fire & axi_master_r_last_i & ~r_empty & r_onehot[k];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < PER_ID_WIDTH; k++) begin
                rd_ptr_q[k] <= '0;
                wr_ptr_q[k] <= '0;
                cnt_q[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < PER_ID_WIDTH; k++) begin
                // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
                if (push[k]) wr_ptr_q[k] <= ptr_inc(wr_ptr_q[k]);
                if (pop[k])  rd_ptr_q[k] <= ptr_inc(rd_ptr_q[k]);
                if (push[k] && !pop[k])      cnt_q[k] <= cnt_q[k] + CNT_W'(1);
                else if (pop[k] && !push[k]) cnt_q[k] <= cnt_q[k] - CNT_W'(1);
            end
        end
    end

    // NOTE: lane storage is not reset; the count gates every read, so stale entries are never observed.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < PER_ID_WIDTH; k++) begin
            if (push[k]) mem_q[k][wr_ptr_q[k]] <= trans_add_i[LANE_W+1:2];
        end
    end

    // Output register: load on grant, drop valid on acceptance, otherwise hold
    always_comb begin
        valid_d   = valid_q;
        opc_d     = opc_q;
        id_d      = id_q;
        rdata_d   = rdata_q;
        arb_ptr_d = arb_ptr_q;
        if (r_fire) begin
            valid_d   = 1'b1;
            opc_d     = axi_master_r_resp_i[1];
            id_d      = r_onehot;
            rdata_d   = rdata_sel;
            arb_ptr_d = 1'b1;
        end else if (b_fire) begin
            valid_d   = 1'b1;
            opc_d     = axi_master_b_resp_i[1];
            id_d      = b_onehot;
            rdata_d   = '0;
            arb_ptr_d = 1'b0;
        end else if (per_slave_r_ready_i) begin
            valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q   <= 1'b0;
            opc_q     <= 1'b0;
            id_q      <= '0;
            rdata_q   <= '0;
            arb_ptr_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            opc_q     <= opc_d;
            id_q      <= id_d;
            rdata_q   <= rdata_d;
            arb_ptr_q <= arb_ptr_d;
        end
    end

    assign per_slave_r_valid_o = valid_q;
    assign per_slave_r_opc_o   = opc_q;
    assign per_slave_r_id_o    = id_q;
    assign per_slave_r_rdata_o = rdata_q;

    // Inputs carried by the protocol but not needed here
    logic unused_bits;
    assign unused_bits = ^{axi_master_r_user_i, axi_master_b_user_i, axi_master_r_resp_i[0],
                           axi_master_b_resp_i[0], trans_add_i};

endmodule

// File: tb/tb_per2axi_res_buffer.sv
module tb_per2axi_res_buffer;

    localparam int P   = 5;
    localparam int AW  = 32;
    localparam int DW  = 128;
    localparam int UW  = 6;
    localparam int IDW = 3;
    localparam int D   = 2;

    logic           clk_i, rst_ni;
    logic           per_valid, per_ready, per_opc;
    logic [P-1:0]   per_id;
    logic [31:0]    per_rdata;
    logic           r_valid, r_last, r_ready;
    logic [DW-1:0]  r_data;
    logic [1:0]     r_resp;
    logic [IDW-1:0] r_id;
    logic [UW-1:0]  r_user;
    logic           b_valid, b_ready;
    logic [1:0]     b_resp;
    logic [IDW-1:0] b_id;
    logic [UW-1:0]  b_user;
    logic           t_req, t_we, t_ready;
    logic [IDW-1:0] t_id;
    logic [AW-1:0]  t_add;

    per2axi_res_buffer #(
        .PER_ID_WIDTH(P), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
        .AXI_USER_WIDTH(UW), .AXI_ID_WIDTH(IDW), .OFFSET_DEPTH(D)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .per_slave_r_valid_o(per_valid), .per_slave_r_ready_i(per_ready),
        .per_slave_r_opc_o(per_opc), .per_slave_r_id_o(per_id),
        .per_slave_r_rdata_o(per_rdata),
        .axi_master_r_valid_i(r_valid), .axi_master_r_data_i(r_data),
        .axi_master_r_resp_i(r_resp), .axi_master_r_last_i(r_last),
        .axi_master_r_id_i(r_id), .axi_master_r_user_i(r_user),
        .axi_master_r_ready_o(r_ready),
        .axi_master_b_valid_i(b_valid), .axi_master_b_resp_i(b_resp),
        .axi_master_b_id_i(b_id), .axi_master_b_user_i(b_user),
        .axi_master_b_ready_o(b_ready),
        .trans_req_i(t_req), .trans_we_i(t_we), .trans_id_i(t_id),
        .trans_add_i(t_add), .trans_ready_o(t_ready)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct {
        logic           t_req, t_we;
        logic [IDW-1:0] t_id;
        logic [AW-1:0]  t_add;
        logic           r_v;
        logic [IDW-1:0] r_id;
        logic [DW-1:0]  r_data;
        logic [1:0]     r_resp;
        logic           r_last;
        logic           b_v;
        logic [IDW-1:0] b_id;
        logic [1:0]     b_resp;
        logic           pr;
        logic           e_rr, e_br, e_tr, e_v;
        logic [P-1:0]   e_id;
        logic           e_opc;
        logic [31:0]    e_rd;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural reference: per-ID queues of lane offsets plus the visible output.
    int unsigned  mq [P][$];
    bit           m_valid;
    logic [P-1:0] m_id;
    bit           m_opc;
    logic [31:0]  m_rdata;
    bit           m_prefer_b;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic tq, input logic tw, input logic [2:0] ti, input logic [31:0] ta,
        input logic rv, input logic [2:0] ri, input logic [127:0] rd, input logic [1:0] rr, input logic rl,
        input logic bv, input logic [2:0] bi, input logic [1:0] br, input logic pr,
        input logic err, input logic ebr, input logic etr,
        input logic ev, input logic [4:0] eid, input logic eopc, input logic [31:0] erd);
        vec_t v;
        v.t_req = tq; v.t_we = tw; v.t_id = ti; v.t_add = ta;
        v.r_v = rv; v.r_id = ri; v.r_data = rd; v.r_resp = rr; v.r_last = rl;
        v.b_v = bv; v.b_id = bi; v.b_resp = br; v.pr = pr;
        v.e_rr = err; v.e_br = ebr; v.e_tr = etr;
        v.e_v = ev; v.e_id = eid; v.e_opc = eopc; v.e_rd = erd;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        t_req = v.t_req; t_we = v.t_we; t_id = v.t_id; t_add = v.t_add;
        r_valid = v.r_v; r_id = v.r_id; r_data = v.r_data; r_resp = v.r_resp; r_last = v.r_last;
        b_valid = v.b_v; b_id = v.b_id; b_resp = v.b_resp; per_ready = v.pr;
    endtask

    task automatic model_reset();
        m_valid = 0; m_id = '0; m_opc = 0; m_rdata = '0; m_prefer_b = 0;
        for (int k = 0; k < P; k++) mq[k].delete();
    endtask

    // One clock cycle: inputs already driven. Checks ready outputs before the
    // edge and the output register after it, against the model (and the table
    // row when use_tbl is set).
    task automatic step(input vec_t v, input bit use_tbl);
        bit r_in, b_in, t_in, r_req, b_req, free, win_r, win_b, e_rr, e_br, e_tr;
        int unsigned lane;
        #1;
        r_in  = int'(r_id) < P;
        b_in  = int'(b_id) < P;
        t_in  = int'(t_id) < P;
        r_req = r_valid && r_in;
        b_req = b_valid && b_in;
        free  = !m_valid || per_ready;
        win_r = r_req && (!b_req || !m_prefer_b);
        win_b = b_req && !win_r;
        e_rr  = !r_in || (free && !(r_req && !win_r));
        e_br  = !b_in || (free && !(b_req && !win_b));
        e_tr  = 1'b1;
        if (!t_we && t_in) e_tr = (mq[t_id].size() < D);
        check("r_ready", r_ready, e_rr);
        check("b_ready", b_ready, e_br);
        check("trans_ready", t_ready, e_tr);
        if (use_tbl) begin
            check("tbl_r_ready", r_ready, v.e_rr);
            check("tbl_b_ready", b_ready, v.e_br);
            check("tbl_trans_ready", t_ready, v.e_tr);
        end
        lane = 0;
        if (r_in && mq[r_id].size() > 0) lane = mq[r_id][0];
        @(posedge clk_i);
        if (win_r && free) begin
            m_valid = 1; m_id = P'(1) << r_id; m_opc = r_resp[1];
            m_rdata = 32'(r_data >> (32 * lane));
            if (r_last && mq[r_id].size() > 0) void'(mq[r_id].pop_front());
            m_prefer_b = 1;
        end else if (win_b && free) begin
            m_valid = 1; m_id = P'(1) << b_id; m_opc = b_resp[1]; m_rdata = '0;
            m_prefer_b = 0;
        end else if (per_ready) begin
            m_valid = 0;
        end
        if (t_req && !t_we && t_in && e_tr) mq[t_id].push_back(int'(t_add[3:2]));
        #1;
        check("valid", per_valid, m_valid);
        if (m_valid) begin
            check("id", per_id, m_id);
            check("opc", per_opc, m_opc);
            check("rdata", per_rdata, m_rdata);
        end
        if (use_tbl) begin
            check("tbl_valid", per_valid, v.e_v);
            if (v.e_v) begin
                check("tbl_id", per_id, v.e_id);
                check("tbl_opc", per_opc, v.e_opc);
                check("tbl_rdata", per_rdata, v.e_rd);
            end
        end
    endtask

    localparam logic [127:0] DA = 128'h0000000D_0000000C_0000000B_0000000A;
    localparam logic [127:0] DB = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] DC = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_12345678;
    localparam logic [127:0] DR = 128'h000000D3_000000C2_000000B1_000000A0;

    vec_t tbl [18];
    vec_t idle;

    initial begin
        idle = mk(0,0,3'd0,32'h0, 0,3'd0,128'h0,2'b00,0, 0,3'd0,2'b00, 1, 0,0,0, 0,5'b0,0,32'h0);
        //            req we id add       rv rid data rresp last  bv bid bresp pr  rr br tr  v id opc rdata
        tbl[0]  = mk(1,0,3'd1,32'h8,  0,3'd0,128'h0,2'b00,0, 0,3'd0,2'b00, 1, 1,1,1, 0,5'b00000,0,32'h0);
        tbl[1]  = mk(0,0,3'd0,32'h0,  1,3'd1,DA,2'b00,1,     0,3'd0,2'b00, 1, 1,1,1, 1,5'b00010,0,32'hC);
        tbl[2]  = mk(1,0,3'd0,32'h4,  0,3'd0,128'h0,2'b00,0, 0,3'd0,2'b00, 1, 1,1,1, 0,5'b00010,0,32'hC);
        tbl[3]  = mk(1,0,3'd0,32'h0,  0,3'd0,128'h0,2'b00,0, 0,3'd0,2'b00, 1, 1,1,1, 0,5'b00010,0,32'hC);
        tbl[4]  = mk(1,0,3'd0,32'hC,  0,3'd0,128'h0,2'b00,0, 0,3'd0,2'b00, 1, 1,1,0, 0,5'b00010,0,32'hC);
        tbl[5]  = mk(0,0,3'd0,32'h0,  1,3'd0,DB,2'b00,1,     0,3'd0,2'b00, 1, 1,1,0, 1,5'b00001,0,32'h22222222);
        tbl[6]  = mk(0,0,3'd0,32'h0,  1,3'd0,DB,2'b00,1,     0,3'd0,2'b00, 1, 1,1,1, 1,5'b00001,0,32'h11111111);
        tbl[7]  = mk(0,0,3'd0,32'h0,  0,3'd0,128'h0,2'b00,0, 1,3'd4,2'b00, 1, 1,1,1, 1,5'b10000,0,32'h0);
        tbl[8]  = mk(0,0,3'd0,32'h0,  1,3'd2,DC,2'b00,1,     1,3'd3,2'b10, 1, 1,0,1, 1,5'b00100,0,32'h12345678);
        tbl[9]  = mk(0,0,3'd0,32'h0,  1,3'd2,DC,2'b00,1,     1,3'd3,2'b10, 1, 0,1,1, 1,5'b01000,1,32'h0);
        tbl[10] = mk(0,0,3'd0,32'h0,  1,3'd2,DC,2'b00,1,     1,3'd3,2'b10, 1, 1,0,1, 1,5'b00100,0,32'h12345678);
        tbl[11] = mk(0,0,3'd0,32'h0,  1,3'd2,DC,2'b00,1,     1,3'd3,2'b10, 1, 0,1,1, 1,5'b01000,1,32'h0);
        tbl[12] = mk(0,0,3'd0,32'h0,  1,3'd2,DC,2'b00,1,     0,3'd0,2'b00, 0, 0,0,1, 1,5'b01000,1,32'h0);
        tbl[13] = mk(0,0,3'd0,32'h0,  1,3'd2,DC,2'b00,1,     0,3'd0,2'b00, 0, 0,0,1, 1,5'b01000,1,32'h0);
        tbl[14] = mk(0,0,3'd0,32'h0,  1,3'd2,DC,2'b00,1,     0,3'd0,2'b00, 1, 1,1,1, 1,5'b00100,0,32'h12345678);
        tbl[15] = mk(0,0,3'd0,32'h0,  0,3'd0,128'h0,2'b00,0, 1,3'd7,2'b10, 1, 1,1,1, 0,5'b00000,0,32'h0);
        tbl[16] = mk(1,0,3'd6,32'h4,  0,3'd0,128'h0,2'b00,0, 0,3'd0,2'b00, 1, 1,1,1, 0,5'b00000,0,32'h0);
        tbl[17] = mk(0,0,3'd0,32'h0,  1,3'd6,DB,2'b00,1,     0,3'd0,2'b00, 0, 1,1,1, 0,5'b00000,0,32'h0);

        r_user = '0; b_user = '0;
        drive(idle);
        model_reset();
        rst_ni = 1'b0;
        #1;
        check("rst_valid", per_valid, 1'b0);
        check("rst_id", per_id, 5'b0);
        check("rst_opc", per_opc, 1'b0);
        check("rst_rdata", per_rdata, 32'h0);
        @(posedge clk_i);
        #2 rst_ni = 1'b1;

        // Directed table: lane select, per-ID ordering, round-robin,
        // back-pressure and out-of-range IDs.
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i]);
            step(tbl[i], 1'b1);
        end

        // Reset mid-stream: fill FIFO 1, leave a response stalled, then reset.
        drive(idle); t_req = 1; t_id = 3'd1; t_add = 32'hC; step(idle, 1'b0);
        t_add = 32'h8; step(idle, 1'b0);
        drive(idle); t_req = 1; t_id = 3'd2; t_add = 32'h4; r_valid = 1; r_id = 3'd3;
        r_data = DB; r_last = 1; per_ready = 0; step(idle, 1'b0);
        drive(idle); per_ready = 0; step(idle, 1'b0);
        check("pre_rst_valid", per_valid, 1'b1);
        #3 rst_ni = 1'b0;
        #1;
        model_reset();
        check("midrst_valid", per_valid, 1'b0);
        check("midrst_id", per_id, 5'b0);
        check("midrst_opc", per_opc, 1'b0);
        check("midrst_rdata", per_rdata, 32'h0);
        @(posedge clk_i);
        #2 rst_ni = 1'b1;
        drive(idle); t_id = 3'd1;
        #1 check("post_rst_trans_ready", t_ready, 1'b1);
        r_valid = 1; r_id = 3'd1; r_data = DR; r_last = 1;
        step(idle, 1'b0);
        check("post_rst_lane0", per_rdata, 32'hA0);
        check("post_rst_id", per_id, 5'b00010);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            t_req     = 1'($urandom_range(0, 1));
            t_we      = ($urandom_range(0, 3) == 0);
            t_id      = IDW'($urandom_range(0, 7));
            t_add     = $urandom;
            r_valid   = 1'($urandom_range(0, 1));
            r_id      = IDW'($urandom_range(0, 7));
            r_data    = {$urandom, $urandom, $urandom, $urandom};
            r_resp    = 2'($urandom_range(0, 3));
            r_last    = ($urandom_range(0, 3) != 0);
            b_valid   = 1'($urandom_range(0, 1));
            b_id      = IDW'($urandom_range(0, 7));
            b_resp    = 2'($urandom_range(0, 3));
            per_ready = ($urandom_range(0, 3) != 0);
            step(idle, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
